// File: rtl/soc_pkg.sv
// soc_pkg: bus FSM states, RV32 size codes and the default SoC address map
package soc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bus_state_e;

    localparam logic [2:0] MASK_B  = 3'b000;
    localparam logic [2:0] MASK_H  = 3'b001;
    localparam logic [2:0] MASK_W  = 3'b010;
    localparam logic [2:0] MASK_BU = 3'b100;
    localparam logic [2:0] MASK_HU = 3'b101;

    // slave 0: data_mem (1 KiB), slaves 1..3: 16-byte peripheral windows
    localparam int             DEF_NUM_SLAVES = 4;
    localparam logic [127:0]   DEF_SLAVE_BASE = {32'h1000_2000, 32'h1000_1000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [31:0]    DEF_SLAVE_AW   = {8'd4, 8'd4, 8'd4, 8'd10};
    localparam int             DEF_TIMEOUT    = 16;

endpackage

// File: rtl/mmio_decoder.sv
// mmio_decoder: priority address decode, window offset and alignment check
module mmio_decoder
    import soc_pkg::*;
#(
    parameter int                         NUM_SLAVES = DEF_NUM_SLAVES,
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE = DEF_SLAVE_BASE,
    parameter logic [NUM_SLAVES*8-1:0]    SLAVE_AW   = DEF_SLAVE_AW
) (
    input  logic [31:0]             addr_i,
    input  logic [2:0]              mask_i,
    output logic [NUM_SLAVES-1:0]   hit_o,
    output logic [31:0]             offset_o,
    output logic                    misalign_o
);

    logic [NUM_SLAVES-1:0] raw;

    // compare the address above each window's size bits against its base
    always_comb begin
        raw = '0;
        for (int k = 0; k < NUM_SLAVES; k++)
            raw[k] = (addr_i >> SLAVE_AW[8*k +: 8]) == (SLAVE_BASE[32*k +: 32] >> SLAVE_AW[8*k +: 8]);
    end

    // isolate the lowest set bit so overlapping windows resolve to the lowest index
    assign hit_o = raw & (-raw);

    // offset relative to the winning base; raw address when nothing hits
    always_comb begin
        offset_o = addr_i;
        for (int k = 0; k < NUM_SLAVES; k++)
            if (hit_o[k]) offset_o = addr_i - SLAVE_BASE[32*k +: 32];
    end

    // reserved size codes are reported as misaligned
    assign misalign_o = (mask_i == MASK_H || mask_i == MASK_HU) ? addr_i[0] :
                        (mask_i == MASK_W) ? |addr_i[1:0] :
                        !(mask_i == MASK_B || mask_i == MASK_BU);

endmodule

// File: rtl/mmio_bus.sv
// mmio_bus: core data port to NUM_SLAVES memory-mapped slaves with decode errors and timeout
module mmio_bus
    import soc_pkg::*;
#(
    parameter int                         NUM_SLAVES = DEF_NUM_SLAVES,
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE = DEF_SLAVE_BASE,
    parameter logic [NUM_SLAVES*8-1:0]    SLAVE_AW   = DEF_SLAVE_AW,
    parameter int                         TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        req_valid_i,
    input  logic                        req_wen_i,
    input  logic [2:0]                  req_mask_i,
    input  logic [31:0]                 req_addr_i,
    input  logic [31:0]                 req_wdata_i,
    output logic                        req_ready_o,
    output logic                        rsp_valid_o,
    output logic [31:0]                 rsp_rdata_o,
    output logic                        rsp_err_o,
    output logic [NUM_SLAVES-1:0]       slv_sel_o,
    output logic                        slv_wen_o,
    output logic [2:0]                  slv_mask_o,
    output logic [31:0]                 slv_addr_o,
    output logic [31:0]                 slv_wdata_o,
    input  logic [NUM_SLAVES*32-1:0]    slv_rdata_i,
    input  logic [NUM_SLAVES-1:0]       slv_ready_i
);

    bus_state_e              state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic                    wen_q, wen_d;
    logic [2:0]              mask_q, mask_d;
    logic [31:0]             addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [31:0]             rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

    logic [NUM_SLAVES-1:0]   dec_hit;
    logic [31:0]             dec_offset;
    logic                    dec_misalign;
    logic [31:0]             sel_rdata;

    mmio_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_AW   (SLAVE_AW)
    ) u_dec (
        .addr_i     (req_addr_i),
        .mask_i     (req_mask_i),
        .hit_o      (dec_hit),
        .offset_o   (dec_offset),
        .misalign_o (dec_misalign)
    );

    // read data of the currently selected slave
    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < NUM_SLAVES; k++)
            if (sel_q[k]) sel_rdata = slv_rdata_i[32*k +: 32];
    end

    // next state: accept and decode in IDLE, wait for ready or timeout in ACCESS, one-cycle RESP
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        wen_d       = wen_q;
        mask_d      = mask_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    wen_d   = req_wen_i;
                    mask_d  = req_mask_i;
                    addr_d  = dec_offset;
                    wdata_d = req_wdata_i;
                    if (|dec_hit && !dec_misalign) begin
                        sel_d   = dec_hit;
                        state_d = ST_ACCESS;
                    end else begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (|(slv_ready_i & sel_q)) begin
                    sel_d       = '0;
                    cnt_d       = '0;
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = wen_q ? 32'd0 : sel_rdata;
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    sel_d       = '0;
                    cnt_d       = '0;
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // state and output registers; reset drops any in-flight transaction
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            wen_q       <= 1'b0;
            mask_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            wen_q       <= wen_d;
            mask_q      <= mask_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign slv_sel_o   = sel_q;
    assign slv_wen_o   = wen_q;
    assign slv_mask_o  = mask_q;
    assign slv_addr_o  = addr_q;
    assign slv_wdata_o = wdata_q;

endmodule

// File: tb/tb_mmio_bus.sv
// tb_mmio_bus: directed and randomized checks of mmio_bus against an address-map model
`timescale 1ns/1ps
module tb_mmio_bus;

    localparam int NS = 4;
    localparam int TO = 16;
    localparam logic [31:0] BASE [NS] = '{32'h0000_0000, 32'h1000_0000, 32'h1000_1000, 32'h1000_2000};
    localparam int AW [NS] = '{10, 4, 4, 4};

    logic            clk_i, reset_i;
    logic            req_valid_i, req_wen_i;
    logic [2:0]      req_mask_i;
    logic [31:0]     req_addr_i, req_wdata_i;
    logic [NS*32-1:0] slv_rdata_i;
    logic [NS-1:0]   slv_ready_i;

    logic            req_ready_o, rsp_valid_o, rsp_err_o, slv_wen_o;
    logic [31:0]     rsp_rdata_o, slv_addr_o, slv_wdata_o;
    logic [NS-1:0]   slv_sel_o;
    logic [2:0]      slv_mask_o;

    logic            o_req_ready, o_rsp_valid, o_rsp_err, o_wen;
    logic [31:0]     o_rsp_rdata, o_addr, o_wdata;
    logic [NS-1:0]   o_sel;
    logic [2:0]      o_mask;

    int n_chk = 0;
    int n_pass = 0;

    mmio_bus u_dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_valid_i(req_valid_i), .req_wen_i(req_wen_i), .req_mask_i(req_mask_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_ready_o(req_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .slv_sel_o(slv_sel_o), .slv_wen_o(slv_wen_o), .slv_mask_o(slv_mask_o),
        .slv_addr_o(slv_addr_o), .slv_wdata_o(slv_wdata_o),
        .slv_rdata_i(slv_rdata_i), .slv_ready_i(slv_ready_i)
    );

    // slave 0 widened to 1 GiB so it overlaps slave 1
    mmio_bus #(.SLAVE_AW({8'd4, 8'd4, 8'd4, 8'd30})) u_ovl (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_valid_i(req_valid_i), .req_wen_i(req_wen_i), .req_mask_i(req_mask_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_ready_o(o_req_ready),
        .rsp_valid_o(o_rsp_valid), .rsp_rdata_o(o_rsp_rdata), .rsp_err_o(o_rsp_err),
        .slv_sel_o(o_sel), .slv_wen_o(o_wen), .slv_mask_o(o_mask),
        .slv_addr_o(o_addr), .slv_wdata_o(o_wdata),
        .slv_rdata_i(slv_rdata_i), .slv_ready_i(slv_ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // address-map model: first window (lowest index) containing the address, plus alignment rules
    function automatic void ref_decode(input logic [31:0] a, input logic [2:0] m, input int aw0,
                                       output int k, output logic err, output logic [31:0] off);
        longint unsigned ua, lo, hi;
        logic mis;
        ua = 64'(a);
        k = -1;
        off = a;
        for (int i = NS - 1; i >= 0; i--) begin
            lo = 64'(BASE[i]);
            hi = lo + (64'd1 << ((i == 0) ? aw0 : AW[i]));
            if (ua >= lo && ua < hi) begin
                k = i;
                off = a - BASE[i];
            end
        end
        case (m)
            3'b000, 3'b100: mis = 1'b0;
            3'b001, 3'b101: mis = (ua % 2) != 0;
            3'b010:         mis = (ua % 4) != 0;
            default:        mis = 1'b1;
        endcase
        err = (k < 0) || mis;
    endfunction

    // one transaction on the default map; waits < 0 means the slave never answers
    task automatic txn(input string tag, input logic wen, input logic [2:0] m, input logic [31:0] a,
                       input logic [31:0] wd, input int waits, input logic [31:0] rd);
        int k;
        logic err, to;
        logic [31:0] off, exp_rd;
        ref_decode(a, m, 10, k, err, off);
        chk({tag, ".idle_ready"}, 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1; req_wen_i = wen; req_mask_i = m; req_addr_i = a; req_wdata_i = wd;
        @(negedge clk_i);
        req_valid_i = 1'b0; req_wen_i = 1'($urandom); req_mask_i = 3'($urandom);
        req_addr_i = $urandom; req_wdata_i = $urandom;
        exp_rd = 32'd0;
        if (!err) begin
            chk({tag, ".sel"}, 32'(slv_sel_o), 32'(4'b1 << k));
            chk({tag, ".offset"}, slv_addr_o, off);
            chk({tag, ".wen"}, 32'(slv_wen_o), 32'(wen));
            chk({tag, ".mask"}, 32'(slv_mask_o), 32'(m));
            chk({tag, ".wdata"}, slv_wdata_o, wd);
            to = 1'b1;
            for (int c = 0; c < TO; c++) begin
                chk({tag, ".busy_ready"}, 32'(req_ready_o), 32'd0);
                chk({tag, ".busy_sel"}, 32'(slv_sel_o), 32'(4'b1 << k));
                chk({tag, ".busy_valid"}, 32'(rsp_valid_o), 32'd0);
                slv_rdata_i = {$urandom, $urandom, $urandom, $urandom};
                slv_ready_i = 4'($urandom) & ~(4'b1 << k);
                if (c == waits) begin
                    slv_ready_i[k] = 1'b1;
                    slv_rdata_i[32*k +: 32] = rd;
                    to = 1'b0;
                end
                @(negedge clk_i);
                slv_ready_i = '0;
                if (!to) break;
            end
            err = to;
            exp_rd = (to || wen) ? 32'd0 : rd;
        end
        chk({tag, ".rsp_valid"}, 32'(rsp_valid_o), 32'd1);
        chk({tag, ".rsp_err"}, 32'(rsp_err_o), 32'(err));
        chk({tag, ".rsp_rdata"}, rsp_rdata_o, exp_rd);
        chk({tag, ".rsp_sel"}, 32'(slv_sel_o), 32'd0);
        chk({tag, ".rsp_ready"}, 32'(req_ready_o), 32'd0);
        @(negedge clk_i);
        chk({tag, ".post_valid"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, ".post_ready"}, 32'(req_ready_o), 32'd1);
        chk({tag, ".hold_rdata"}, rsp_rdata_o, exp_rd);
        chk({tag, ".hold_err"}, 32'(rsp_err_o), 32'(err));
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0] m;
        int pick, waits;
        reset_i = 1'b1; req_valid_i = 1'b0; req_wen_i = 1'b0; req_mask_i = '0;
        req_addr_i = '0; req_wdata_i = '0; slv_rdata_i = '0; slv_ready_i = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst.ready", 32'(req_ready_o), 32'd1);
        chk("rst.valid", 32'(rsp_valid_o), 32'd0);
        chk("rst.err", 32'(rsp_err_o), 32'd0);
        chk("rst.rdata", rsp_rdata_o, 32'd0);
        chk("rst.sel", 32'(slv_sel_o), 32'd0);
        chk("rst.wen", 32'(slv_wen_o), 32'd0);
        chk("rst.mask", 32'(slv_mask_o), 32'd0);
        chk("rst.addr", slv_addr_o, 32'd0);
        chk("rst.wdata", slv_wdata_o, 32'd0);
        reset_i = 1'b0;
        @(negedge clk_i);

        txn("ld0", 1'b0, 3'b010, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF);
        txn("st1", 1'b1, 3'b010, 32'h1000_0004, 32'h1234_5678, 3, 32'hCAFE_F00D);
        txn("unmapped", 1'b0, 3'b010, 32'h2000_0000, 32'h0, 0, 32'h1111_1111);
        txn("mis_h", 1'b0, 3'b001, 32'h0000_0003, 32'h0, 0, 32'h2222_2222);
        txn("timeout", 1'b0, 3'b010, 32'h1000_1000, 32'h0, -1, 32'h3333_3333);

        // reset while a slave access is pending
        req_valid_i = 1'b1; req_wen_i = 1'b0; req_mask_i = 3'b010; req_addr_i = 32'h1000_0000;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("rstmid.sel_before", 32'(slv_sel_o), 32'h2);
        reset_i = 1'b1;
        @(negedge clk_i);
        chk("rstmid.sel", 32'(slv_sel_o), 32'd0);
        chk("rstmid.ready", 32'(req_ready_o), 32'd1);
        chk("rstmid.valid", 32'(rsp_valid_o), 32'd0);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("rstmid.no_rsp", 32'(rsp_valid_o), 32'd0);
        chk("rstmid.idle", 32'(req_ready_o), 32'd1);

        // overlapping windows: lowest index wins
        req_valid_i = 1'b1; req_wen_i = 1'b0; req_mask_i = 3'b010; req_addr_i = 32'h1000_0008;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("ovl.sel_default", 32'(slv_sel_o), 32'h2);
        chk("ovl.off_default", slv_addr_o, 32'h8);
        chk("ovl.sel_wide", 32'(o_sel), 32'h1);
        chk("ovl.off_wide", o_addr, 32'h1000_0008);
        slv_rdata_i = {32'h0, 32'h0, 32'hBBBB_0001, 32'hAAAA_0000};
        slv_ready_i = 4'b0011;
        @(negedge clk_i);
        slv_ready_i = '0;
        chk("ovl.rd_default", rsp_rdata_o, 32'hBBBB_0001);
        chk("ovl.rd_wide", o_rsp_rdata, 32'hAAAA_0000);
        chk("ovl.valid_wide", 32'(o_rsp_valid), 32'd1);
        @(negedge clk_i);

        // back-to-back with valid held high: one accept every 3 cycles
        req_valid_i = 1'b1; req_wen_i = 1'b0; req_mask_i = 3'b000; req_addr_i = 32'h0000_0021;
        slv_rdata_i = {96'h0, 32'h5A5A_A5A5};
        slv_ready_i = 4'b0001;
        for (int i = 0; i < 9; i++) begin
            chk("b2b.ready", 32'(req_ready_o), 32'(i % 3 == 0));
            chk("b2b.valid", 32'(rsp_valid_o), 32'(i % 3 == 2));
            if (i % 3 == 2) chk("b2b.rdata", rsp_rdata_o, 32'h5A5A_A5A5);
            @(negedge clk_i);
        end
        req_valid_i = 1'b0;
        slv_ready_i = '0;
        @(negedge clk_i);

        // randomized transactions over the whole map
        for (int t = 0; t < 40; t++) begin
            pick = $urandom_range(0, 5);
            if (pick < NS) begin
                a = BASE[pick] + ($urandom & ((32'd1 << AW[pick]) - 1));
                if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
            end else if (pick == NS) a = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFC);
            else a = $urandom;
            case ($urandom_range(0, 7))
                0: m = 3'b000;
                1: m = 3'b001;
                2, 3: m = 3'b010;
                4: m = 3'b100;
                5: m = 3'b101;
                6: m = 3'b011;
                default: m = 3'b110;
            endcase
            waits = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 5);
            txn("rand", 1'($urandom), m, a, $urandom, waits, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mmio_bus.md
Name: mmio_bus

Overview:
- Parametrised data-side interconnect between the core's data-memory port and NUM_SLAVES memory-mapped slaves (data_mem, timers, GPIO, UART, ...).
- Replaces the fixed one-core-one-data-memory wiring in the SoC top.
- Adds a valid/ready handshake, per-slave address windows, variable slave wait states, misalignment/decode errors and a bus timeout.
- Sits in the core clock domain, between the core and its slaves.

Parameters:
- NUM_SLAVES, 4, number of slave channels (1..8).
- SLAVE_BASE, {32'h0000_0000, 32'h1000_0000, 32'h1000_1000, 32'h1000_2000}, flattened NUM_SLAVES*32 base addresses; slave k occupies bits [32k+31:32k].
- SLAVE_AW, {8'd10, 8'd4, 8'd4, 8'd4}, flattened NUM_SLAVES*8; log2 window size of slave k in bytes; base must be aligned to the window size.
- TIMEOUT, 16, maximum cycles in ACCESS before an error response (2..255).

Ports:
- clk_i  in  1  core clock
- reset_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  core request valid
- req_wen_i  in  1  1 = store, 0 = load
- req_mask_i  in  3  RV32 funct3 size code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data
- req_ready_o  out  1  request accepted this cycle
- rsp_valid_o  out  1  one-cycle response strobe
- rsp_rdata_o  out  32  load data; 0 on error and on stores
- rsp_err_o  out  1  decode, misalignment or timeout error
- slv_sel_o  out  NUM_SLAVES  one-hot slave select
- slv_wen_o  out  1  latched write enable
- slv_mask_o  out  3  latched size code
- slv_addr_o  out  32  offset within the window (addr minus base)
- slv_wdata_o  out  32  latched store data
- slv_rdata_i  in  NUM_SLAVES*32  flattened slave read data
- slv_ready_i  in  NUM_SLAVES  slave completes access

Behaviour:
- Reset values:
  - state IDLE
  - req_ready_o=1
  - rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0
  - slv_sel_o=0, slv_wen_o=0, slv_mask_o=0, slv_addr_o=0, slv_wdata_o=0
  - timeout counter 0
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready_o=1; handshake completes when req_valid_i=1.
  - On a completed handshake, latch wen, mask, offset and wdata, then decode.
  - Hit and aligned: set slv_sel_o one-hot on the winning slave and go to ACCESS.
  - No hit, or misaligned (h/hu with addr[0]=1; w with addr[1:0]!=0; reserved mask code): go to RESP with err=1. No slave is selected.
- Decode rule:
  - Slave k hits when addr[31:SLAVE_AW_k] == base[31:SLAVE_AW_k].
  - Overlapping windows: the lowest index wins.
- ACCESS:
  - req_ready_o=0; slave outputs held stable.
  - On slv_ready_i[k]=1 for the selected k: capture slv_rdata_i[k] (forced to 0 if wen), clear sel, go to RESP with err=0.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no ready: clear sel, go to RESP with err=1, rdata=0.
  - Ready from non-selected slaves is ignored.
- RESP:
  - rsp_valid_o=1 for exactly one cycle; rsp_rdata_o/rsp_err_o are valid that cycle and hold until the next response.
  - req_ready_o=0; counter cleared; next state IDLE.
- Latency:
  - Zero-wait slave (ready in first ACCESS cycle): rsp_valid 2 cycles after the accept edge.
  - Each wait cycle adds 1.
  - Error in IDLE: rsp_valid 1 cycle after accept.
- Throughput: at most one transaction per 2 (error) or 3 (hit) cycles; no outstanding transactions.
- Requests presented while req_ready_o=0 are not accepted. The core must hold req_* until req_ready_o=1.
- Reset mid-ACCESS or mid-RESP: returns immediately to IDLE with reset values; the in-flight transaction is dropped with no response.
- Sign/zero extension of loads is done by the core or slave; the bus passes 32-bit data unchanged.

Decomposition:
- Shared package soc_pkg:
  - FSM state encodings
  - size-code constants (MASK_B, MASK_H, MASK_W, MASK_BU, MASK_HU)
  - default SoC address-map constants
- One combinational sub-module, mmio_decoder:
  - Inputs: addr, mask.
  - Outputs: one-hot hit vector (priority-resolved), offset, misalign flag.
  - Instantiated once.

Test Plan:
- Reset asserted mid-ACCESS on slave 1 -> next edge: slv_sel_o=0, req_ready_o=1, no rsp_valid_o.
- Load w 0x0000_0010, slave 0 ready immediately with rdata 0xDEAD_BEEF -> slv_sel_o=0001, slv_addr_o=0x10; rsp_valid 2 cycles after accept, rdata 0xDEAD_BEEF, err 0.
- Store w 0x1000_0004, wdata 0x1234_5678, slave 1 ready after 3 wait cycles -> sel=0010, offset 0x4, wen 1, data held for 4 cycles; rsp_valid at cycle 5, rdata 0, err 0.
- Load w 0x2000_0000 (unmapped) -> no sel; rsp_valid 1 cycle after accept, err 1, rdata 0.
- Load h 0x0000_0003 -> misaligned, no sel, err 1. Load w 0x1000_1000, slave 2 never ready -> sel held TIMEOUT=16 cycles, then err 1, sel 0.
- Back-to-back requests with req_valid_i held high -> accepts spaced 3 cycles apart, one rsp_valid per accept; overlapping window test (slave 0 AW 30 covers slave 1) -> slave 0 wins.
